// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: store width encoding and drain controller states.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } store_width_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_ISSUE,
    LOAD_WAIT,
    STORE_ISSUE
  } drain_state_t;

endpackage

// File: rtl/store_buffer_drain_controller_starve.sv
// Saturating count of load grants that bypassed a waiting committed store.
module store_starve_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign at_limit_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/store_buffer_drain_controller.sv
// Arbitrates the single memory port between load reads and store-buffer drains,
// answering forwarded loads without a memory access.
module store_buffer_drain_controller
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  load_req_i,
  input  logic [ADDR_WIDTH-1:0] load_address_i,
  output logic                  load_ready_o,
  output logic                  load_valid_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  input  logic                  buf_empty_i,
  input  logic                  buf_full_i,
  input  logic                  buf_valid_i,
  input  logic [ADDR_WIDTH-1:0] buf_address_i,
  input  logic [DATA_WIDTH-1:0] buf_data_i,
  input  logic [1:0]            buf_width_i,
  output logic                  pull_request_o,
  output logic [ADDR_WIDTH-1:0] fwd_address_o,
  input  logic                  fwd_match_i,
  input  logic [DATA_WIDTH-1:0] fwd_data_i,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [1:0]            mem_width_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  drain_state_t          state_q;
  logic                  mem_read_q, mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  store_width_t          mem_width_q;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic                  load_valid_q, fwd_valid_q, kill_q;

  logic store_ready, force_store, load_accept, starved, starve_inc, starve_clr;

  assign store_ready   = buf_valid_i & ~buf_empty_i;
  assign force_store   = store_ready & (buf_full_i | starved);
  assign load_ready_o  = (state_q == IDLE) & ~flush_i & ~force_store;
  assign load_accept   = load_ready_o & load_req_i;
  assign fwd_address_o = load_address_i;

  assign starve_inc = load_accept & ~fwd_match_i & store_ready;
  assign starve_clr = (state_q == IDLE) & ~load_accept & store_ready;

  store_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .inc_i     (starve_inc),
    .clr_i     (starve_clr),
    .at_limit_o(starved)
  );

  // The store buffer pops on the same cycle memory takes the write.
  assign pull_request_o = mem_write_q & mem_ready_i;

  // A forwarded result is registered, so a flush in its return cycle still cancels it.
  assign load_valid_o  = load_valid_q | (fwd_valid_q & ~flush_i);
  assign load_data_o   = load_data_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_address_o = mem_address_q;
  assign mem_data_o    = mem_data_q;
  assign mem_width_o   = mem_width_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_width_q   <= BYTE;
      load_data_q   <= '0;
      load_valid_q  <= 1'b0;
      fwd_valid_q   <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      fwd_valid_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_accept) begin
            if (fwd_match_i) begin
              fwd_valid_q <= 1'b1;
              load_data_q <= fwd_data_i;
            end else begin
              mem_address_q <= load_address_i;
              mem_read_q    <= 1'b1;
              kill_q        <= 1'b0;
              state_q       <= LOAD_ISSUE;
            end
          end else if (store_ready) begin
            mem_address_q <= buf_address_i;
            mem_data_q    <= buf_data_i;
            mem_width_q   <= store_width_t'(buf_width_i);
            mem_write_q   <= 1'b1;
            state_q       <= STORE_ISSUE;
          end
        end
        LOAD_ISSUE: begin
          if (flush_i) kill_q <= 1'b1;
          if (mem_ready_i) begin
            mem_read_q <= 1'b0;
            state_q    <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (flush_i) kill_q <= 1'b1;
          if (mem_rvalid_i) begin
            load_valid_q <= ~(kill_q | flush_i);
            load_data_q  <= mem_rdata_i;
            state_q      <= IDLE;
          end
        end
        STORE_ISSUE: begin
          // Committed stores complete regardless of flush.
          if (mem_ready_i) begin
            mem_write_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer_drain_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_store_buffer_drain_controller;
  import load_store_unit_pkg::*;

  localparam int unsigned SL = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  w;
  } sb_entry_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        load_req_i = 1'b0;
  logic [31:0] load_address_i = '0;
  logic        load_ready_o, load_valid_o;
  logic [31:0] load_data_o;
  logic        buf_empty_i = 1'b1, buf_full_i = 1'b0, buf_valid_i = 1'b0;
  logic [31:0] buf_address_i = '0, buf_data_i = '0;
  logic [1:0]  buf_width_i = '0;
  logic        pull_request_o;
  logic [31:0] fwd_address_o;
  logic        fwd_match_i = 1'b0;
  logic [31:0] fwd_data_i = '0;
  logic        mem_read_o, mem_write_o;
  logic [31:0] mem_address_o, mem_data_o;
  logic [1:0]  mem_width_o;
  logic        mem_ready_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  store_buffer_drain_controller #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(SL)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .load_req_i(load_req_i), .load_address_i(load_address_i), .load_ready_o(load_ready_o),
    .load_valid_o(load_valid_o), .load_data_o(load_data_o),
    .buf_empty_i(buf_empty_i), .buf_full_i(buf_full_i), .buf_valid_i(buf_valid_i),
    .buf_address_i(buf_address_i), .buf_data_i(buf_data_i), .buf_width_i(buf_width_i),
    .pull_request_o(pull_request_o), .fwd_address_o(fwd_address_o),
    .fwd_match_i(fwd_match_i), .fwd_data_i(fwd_data_i),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_address_o(mem_address_o),
    .mem_data_o(mem_data_o), .mem_width_o(mem_width_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;
  int n_reads, n_read_cycles, n_writes, n_write_cycles, n_pulls, n_lvalid, n_accept;
  int overlap, reads_at_write, n_blocked, starve_obs, starve_max;
  bit last_accept, last_load_ready, last_mem_read;
  logic [31:0] last_ldata, last_waddr, last_wdata, last_mem_addr, rv_data;
  logic [1:0]  last_wwidth;
  int mem_hold = 0, rv_cnt = 0, rv_delay = 1;
  bit rand_ready = 0, rdata_ovr = 0, force_full = 0, scoreboard = 0;
  sb_entry_t   sb_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return rdata_ovr ? 32'h0000_00AA : ((a * 32'h0000_9E37) ^ 32'h1357_2468);
  endfunction

  task automatic update_buf();
    buf_empty_i = (sb_q.size() == 0);
    buf_full_i  = force_full || (sb_q.size() >= 4);
    if (sb_q.size() > 0) begin
      buf_address_i = sb_q[0].a;
      buf_data_i    = sb_q[0].d;
      buf_width_i   = sb_q[0].w;
    end
  endtask

  task automatic clear_stats();
    n_reads = 0; n_read_cycles = 0; n_writes = 0; n_write_cycles = 0; n_pulls = 0;
    n_lvalid = 0; n_accept = 0; overlap = 0; reads_at_write = -1; n_blocked = 0;
    starve_obs = 0; starve_max = 0; last_accept = 0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0; load_req_i = 0; flush_i = 0; fwd_match_i = 0; buf_valid_i = 0;
    force_full = 0; sb_q.delete(); exp_q.delete(); mem_hold = 0; rv_cnt = 0; rv_delay = 1;
    rand_ready = 0; rdata_ovr = 0; scoreboard = 0; mem_ready_i = 0; mem_rvalid_i = 0;
    update_buf();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    clear_stats();
  endtask

  // One clock: memory/buffer responders, observation, model updates; returns at next negedge.
  task automatic cyc();
    sb_entry_t   e;
    logic [31:0] ed;
    bit          sr;
    update_buf();
    if (mem_hold > 0) begin
      mem_ready_i = 1'b0;
      mem_hold--;
    end else if (rand_ready) mem_ready_i = ($urandom_range(0, 1) == 1);
    else mem_ready_i = 1'b1;
    mem_rvalid_i = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rv_data;
      end
    end
    #1;
    sr = buf_valid_i && !buf_empty_i;
    last_load_ready = load_ready_o;
    last_mem_read   = mem_read_o;
    last_mem_addr   = mem_address_o;
    last_accept     = load_ready_o && load_req_i;
    if (mem_read_o) n_read_cycles++;
    if (mem_write_o) n_write_cycles++;
    if (mem_read_o && mem_write_o) overlap++;
    if (load_req_i && !load_ready_o && !flush_i && !mem_read_o && !mem_write_o &&
        rv_cnt == 0 && !mem_rvalid_i) n_blocked++;
    if (mem_read_o && mem_ready_i) begin
      n_reads++;
      rv_cnt  = rand_ready ? int'($urandom_range(1, 3)) : rv_delay;
      rv_data = mem_fn(mem_address_o);
    end
    if (last_accept) begin
      n_accept++;
      if (scoreboard) exp_q.push_back(fwd_match_i ? fwd_data_i : mem_fn(load_address_i));
      if (!fwd_match_i && sr) begin
        starve_obs++;
        if (starve_obs > starve_max) starve_max = starve_obs;
      end
    end
    if (load_valid_o) begin
      n_lvalid++;
      last_ldata = load_data_o;
      if (scoreboard) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_load_result got=%h required=no_result", load_data_o);
        end else begin
          ed = exp_q.pop_front();
          if (load_data_o !== ed) begin
            failures++;
            $display("FAIL rand_load_result got=%h required=%h", load_data_o, ed);
          end
        end
      end
    end
    if (pull_request_o) n_pulls++;
    if (mem_write_o && mem_ready_i) begin
      n_writes++;
      last_waddr = mem_address_o; last_wdata = mem_data_o; last_wwidth = mem_width_o;
      if (reads_at_write < 0) reads_at_write = n_reads;
      starve_obs = 0;
      checks++;
      if (pull_request_o !== 1'b1) begin
        failures++;
        $display("FAIL pull_with_write got=%b required=1", pull_request_o);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (scoreboard) begin
          checks++;
          if ({mem_address_o, mem_data_o, mem_width_o} !== {e.a, e.d, e.w}) begin
            failures++;
            $display("FAIL rand_store_drain got=%h/%h/%0d required=%h/%h/%0d",
                     mem_address_o, mem_data_o, mem_width_o, e.a, e.d, e.w);
          end
        end
      end
      update_buf();
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if ({load_valid_o, pull_request_o, mem_read_o, mem_write_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b required=0000",
               {load_valid_o, pull_request_o, mem_read_o, mem_write_o});
    end
    checks++;
    if ({mem_address_o, mem_data_o, mem_width_o, load_data_o} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%0d/%h required=0", mem_address_o, mem_data_o,
               mem_width_o, load_data_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    checks++;
    if (load_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle_ready got=%b required=1", load_ready_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_store_drain();
    do_reset();
    sb_q.push_back('{a: 32'h100, d: 32'hDEADBEEF, w: WORD});
    buf_valid_i = 1'b1;
    repeat (6) cyc();
    checks++;
    if (n_writes != 1 || n_write_cycles != 1 || n_pulls != 1) begin
      failures++;
      $display("FAIL drain_counts got=%0d/%0d/%0d required=1/1/1", n_writes, n_write_cycles,
               n_pulls);
    end
    checks++;
    if ({last_waddr, last_wdata, last_wwidth} !== {32'h100, 32'hDEADBEEF, 2'd2}) begin
      failures++;
      $display("FAIL drain_values got=%h/%h/%0d required=100/deadbeef/2", last_waddr,
               last_wdata, last_wwidth);
    end
    checks++;
    if (n_read_cycles != 0 || last_load_ready !== 1'b1) begin
      failures++;
      $display("FAIL drain_idle got=%0d/%b required=0/1", n_read_cycles, last_load_ready);
    end
  endtask

  task automatic test_forward();
    do_reset();
    load_address_i = 32'h200; fwd_match_i = 1; fwd_data_i = 32'h12345678; load_req_i = 1;
    #1;
    checks++;
    if (fwd_address_o !== 32'h200) begin
      failures++;
      $display("FAIL fwd_address got=%h required=00000200", fwd_address_o);
    end
    cyc();
    load_req_i = 0; fwd_match_i = 0;
    cyc();
    checks++;
    if (n_lvalid != 1 || last_ldata !== 32'h12345678) begin
      failures++;
      $display("FAIL fwd_result got=%0d/%h required=1/12345678", n_lvalid, last_ldata);
    end
    repeat (3) cyc();
    checks++;
    if (n_read_cycles != 0 || n_lvalid != 1) begin
      failures++;
      $display("FAIL fwd_no_mem got=%0d/%0d required=0/1", n_read_cycles, n_lvalid);
    end
    // Flush in the return cycle drops the forwarded result.
    load_req_i = 1; fwd_match_i = 1; fwd_data_i = 32'h0BADF00D;
    cyc();
    load_req_i = 0; fwd_match_i = 0; flush_i = 1;
    cyc();
    flush_i = 0;
    repeat (2) cyc();
    checks++;
    if (n_accept != 2 || n_lvalid != 1) begin
      failures++;
      $display("FAIL fwd_flush got=%0d/%0d required=2/1", n_accept, n_lvalid);
    end
    flush_i = 1; load_req_i = 1; fwd_match_i = 1; fwd_data_i = 32'h600DCAFE;
    #1;
    checks++;
    if (load_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_flush_block got=%b required=0", load_ready_o);
    end
    cyc();
    flush_i = 0;
    cyc();
    load_req_i = 0; fwd_match_i = 0;
    cyc();
    checks++;
    if (n_accept != 3 || n_lvalid != 2 || last_ldata !== 32'h600DCAFE) begin
      failures++;
      $display("FAIL idle_flush_resume got=%0d/%0d/%h required=3/2/600dcafe", n_accept,
               n_lvalid, last_ldata);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    sb_q.push_back('{a: 32'h400, d: 32'hCAFEF00D, w: HALF});
    buf_valid_i = 1; load_req_i = 1; load_address_i = 32'h1000; fwd_match_i = 0;
    for (int i = 0; i < 100 && n_writes == 0; i++) begin
      cyc();
      if (last_accept) load_address_i = load_address_i + 32'd4;
    end
    checks++;
    if (n_writes != 1 || reads_at_write != SL) begin
      failures++;
      $display("FAIL starve_force got=%0d/%0d required=1/%0d", n_writes, reads_at_write, SL);
    end
    checks++;
    if (n_blocked != 1) begin
      failures++;
      $display("FAIL starve_block got=%0d required=1", n_blocked);
    end
    for (int i = 0; i < 60 && n_reads < SL + 2; i++) cyc();
    checks++;
    if (n_reads != SL + 2) begin
      failures++;
      $display("FAIL starve_resume got=%0d required=%0d", n_reads, SL + 2);
    end
    load_req_i = 0;
    repeat (6) cyc();
  endtask

  task automatic test_full();
    do_reset();
    sb_q.push_back('{a: 32'h600, d: 32'h5555AAAA, w: BYTE});
    buf_valid_i = 1; force_full = 1; load_req_i = 1; load_address_i = 32'h500; fwd_match_i = 0;
    for (int i = 0; i < 30 && n_accept == 0; i++) begin
      cyc();
      if (n_writes > 0) force_full = 0;
    end
    load_req_i = 0;
    checks++;
    if (n_accept != 1 || n_writes != 1 || n_blocked != 1) begin
      failures++;
      $display("FAIL full_order got=%0d/%0d/%0d required=1/1/1", n_accept, n_writes, n_blocked);
    end
    for (int i = 0; i < 20 && n_lvalid == 0; i++) cyc();
    checks++;
    if (n_lvalid != 1 || last_ldata !== mem_fn(32'h500)) begin
      failures++;
      $display("FAIL full_load got=%0d/%h required=1/%h", n_lvalid, last_ldata, mem_fn(32'h500));
    end
  endtask

  task automatic test_flush_load();
    int held;
    do_reset();
    rdata_ovr = 1; rv_delay = 2; load_address_i = 32'h300; load_req_i = 1; fwd_match_i = 0;
    cyc();
    load_req_i = 0; load_address_i = 32'h0; mem_hold = 3;
    held = 0;
    repeat (3) begin
      cyc();
      if (last_mem_read && last_mem_addr == 32'h300) held++;
    end
    checks++;
    if (held != 3 || n_reads != 0) begin
      failures++;
      $display("FAIL read_hold got=%0d/%0d required=3/0", held, n_reads);
    end
    cyc();
    flush_i = 1;
    cyc();
    flush_i = 0;
    repeat (4) cyc();
    #1;
    checks++;
    if (n_reads != 1 || n_lvalid != 0 || load_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_kill got=%0d/%0d/%b required=1/0/1", n_reads, n_lvalid, load_ready_o);
    end
    rv_delay = 1; load_address_i = 32'h304; load_req_i = 1;
    cyc();
    load_req_i = 0;
    for (int i = 0; i < 20 && n_lvalid == 0; i++) cyc();
    checks++;
    if (n_lvalid != 1 || last_ldata !== 32'hAA) begin
      failures++;
      $display("FAIL post_flush_load got=%0d/%h required=1/000000aa", n_lvalid, last_ldata);
    end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    sb_q.push_back('{a: 32'h700, d: 32'h0F0F0F0F, w: WORD});
    buf_valid_i = 1; mem_hold = 10;
    repeat (2) cyc();
    checks++;
    if (mem_write_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_store_active got=%b required=1", mem_write_o);
    end
    #2;
    rst_n_i = 1'b0;
    mem_ready_i = 1'b1;
    #1;
    checks++;
    if ({mem_write_o, mem_read_o, pull_request_o, load_valid_o} !== 4'b0 ||
        {mem_address_o, mem_data_o, mem_width_o} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b/%h/%h required=0", {mem_write_o, mem_read_o,
               pull_request_o, load_valid_o}, mem_address_o, mem_data_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1; mem_hold = 0; rv_cnt = 0;
    clear_stats();
    for (int i = 0; i < 20 && n_writes == 0; i++) cyc();
    repeat (2) cyc();
    checks++;
    if (n_writes != 1 || n_pulls != 1 || last_waddr !== 32'h700) begin
      failures++;
      $display("FAIL store_reissue got=%0d/%0d/%h required=1/1/00000700", n_writes, n_pulls,
               last_waddr);
    end
  endtask

  task automatic test_random();
    do_reset();
    rand_ready = 1; scoreboard = 1;
    for (int c = 0; c < 800; c++) begin
      if (sb_q.size() < 4 && $urandom_range(0, 3) == 0)
        sb_q.push_back('{a: $urandom, d: $urandom, w: 2'($urandom_range(0, 2))});
      buf_valid_i = ($urandom_range(0, 7) != 0);
      if (!load_req_i && $urandom_range(0, 2) == 0) begin
        load_req_i     = 1;
        load_address_i = $urandom & 32'hFFFF_FFFC;
        fwd_match_i    = ($urandom_range(0, 3) == 0);
        fwd_data_i     = $urandom;
      end
      cyc();
      if (last_accept) begin
        load_req_i = 0; fwd_match_i = 0;
      end
    end
    load_req_i = 0; buf_valid_i = 1;
    for (int i = 0; i < 300 && (sb_q.size() > 0 || exp_q.size() > 0 || rv_cnt > 0); i++) cyc();
    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0 || sb_q.size() != 0 || n_lvalid != n_accept) begin
      failures++;
      $display("FAIL rand_drain got=%0d/%0d/%0d required=0/0/%0d", exp_q.size(), sb_q.size(),
               n_lvalid, n_accept);
    end
    checks++;
    if (overlap != 0 || n_pulls != n_writes) begin
      failures++;
      $display("FAIL rand_bus got=%0d/%0d required=0/%0d", overlap, n_pulls, n_writes);
    end
    checks++;
    if (starve_max > SL) begin
      failures++;
      $display("FAIL rand_starve got=%0d required<=%0d", starve_max, SL);
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_store_drain();
    test_forward();
    test_starvation();
    test_full();
    test_flush_load();
    test_reset_mid_store();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
